// File: rtl/inst_buffer_pkg.sv
// rtl/inst_buffer_pkg.sv - shared core defines for the instruction buffer
// Purpose: buffer depth default, pointer typedef (index plus wrap bit) and
//          the DEPTH/width legality check used at elaboration.
// Ports:   none (package).
package inst_buffer_pkg;

  localparam int IBUF_DEPTH = 16;
  localparam int IBUF_IDX_W = $clog2(IBUF_DEPTH);
  localparam int IBUF_PTR_W = IBUF_IDX_W + 1;

  // Wrap bit sits above the index so that tail - head over the whole
  // struct yields the occupancy, distinguishing full from empty.
  typedef struct packed {
    logic                  wrap;
    logic [IBUF_IDX_W-1:0] idx;
  } ibuf_ptr_t;

  // The pointer typedef is sized from IBUF_DEPTH, so the instance depth
  // must match it; depth must also be a power of two and hold one fetch
  // group plus one decode group.
  function automatic bit ibuf_cfg_ok(input int depth, input int fetch_w,
                                     input int decode_w);
    return (depth == IBUF_DEPTH) && ((depth & (depth - 1)) == 0) &&
           (fetch_w > 0) && (decode_w > 0) && (depth >= fetch_w + decode_w);
  endfunction

endpackage

// File: rtl/inst_buffer_fetch_compact.sv
// rtl/inst_buffer_fetch_compact.sv - packs valid fetch lanes into ascending order
// Purpose: prefix-popcount of in_valid gives each valid lane its write
//          offset; lanes are packed to the low slots of comp_data.
// Ports:   in_valid  - per-lane valid from IFU
//          in_data   - lane payloads, lane 0 in LSBs
//          comp_data - compacted payloads, slot 0 in LSBs
//          comp_num  - number of valid lanes
module fetch_compact
  import inst_buffer_pkg::*;
#(
  parameter int FETCH_WIDTH = 4,
  parameter int DATA_WIDTH  = 96,
  localparam int NUM_W      = $clog2(FETCH_WIDTH + 1)
) (
  input  logic [FETCH_WIDTH-1:0]            in_valid,
  input  logic [FETCH_WIDTH*DATA_WIDTH-1:0] in_data,
  output logic [FETCH_WIDTH*DATA_WIDTH-1:0] comp_data,
  output logic [NUM_W-1:0]                  comp_num
);

  // Running popcount of the lanes below lane i = write offset of lane i.
  logic [NUM_W-1:0] offset;

  always_comb begin
    offset    = '0;
    comp_data = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (in_valid[i]) begin
        comp_data[int'(offset)*DATA_WIDTH +: DATA_WIDTH] = in_data[i*DATA_WIDTH +: DATA_WIDTH];
        offset = offset + NUM_W'(1);
      end
    end
    comp_num = offset;
  end

endmodule

// File: rtl/inst_buffer.sv
// rtl/inst_buffer.sv - instruction buffer between IFU and Decode
// Purpose: circular buffer accepting up to FETCH_WIDTH compacted lanes and
//          presenting up to DECODE_WIDTH oldest lanes per cycle.
//          Optional macro IBUF_BYPASS_EN: when empty and not stalled,
//          incoming lanes are forwarded combinationally to Decode.
// Ports:   clk, rst (async active-low), flush (discard all contents)
//          in_valid/in_data/in_ready - fetch group from IFU
//          stall                     - Decode back-pressure
//          out_valid/out_data        - lanes to Decode, contiguous from lane 0
//          count                     - current occupancy
module inst_buffer
  import inst_buffer_pkg::*;
#(
  parameter int FETCH_WIDTH  = 4,
  parameter int DECODE_WIDTH = 4,
  parameter int DEPTH        = IBUF_DEPTH,
  parameter int DATA_WIDTH   = 96,
  localparam int CNT_W       = $clog2(DEPTH + 1)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               flush,
  input  logic [FETCH_WIDTH-1:0]             in_valid,
  input  logic [FETCH_WIDTH*DATA_WIDTH-1:0]  in_data,
  output logic                               in_ready,
  input  logic                               stall,
  output logic [DECODE_WIDTH-1:0]            out_valid,
  output logic [DECODE_WIDTH*DATA_WIDTH-1:0] out_data,
  output logic [CNT_W-1:0]                   count
);

  localparam int IDX_W = IBUF_IDX_W;
  localparam int PTR_W = IBUF_PTR_W;
  localparam int ENQ_W = $clog2(FETCH_WIDTH + 1);

  if (!ibuf_cfg_ok(DEPTH, FETCH_WIDTH, DECODE_WIDTH)) begin : g_cfg_err
    $error("inst_buffer: illegal DEPTH/width configuration");
  end

  ibuf_ptr_t                        head, tail;
  logic [DATA_WIDTH-1:0]            mem [DEPTH];
  logic [PTR_W-1:0]                 occ;
  logic [FETCH_WIDTH*DATA_WIDTH-1:0] comp_data;
  logic [ENQ_W-1:0]                 comp_num;
  logic                             enq_fire;
  logic [PTR_W-1:0]                 fwd_num;
  logic [PTR_W-1:0]                 enq_wr;
  logic [PTR_W-1:0]                 deq_num;

  fetch_compact #(
    .FETCH_WIDTH (FETCH_WIDTH),
    .DATA_WIDTH  (DATA_WIDTH)
  ) u_compact (
    .in_valid  (in_valid),
    .in_data   (in_data),
    .comp_data (comp_data),
    .comp_num  (comp_num)
  );

  // Occupancy from the wrap-extended pointers: 0 = empty, DEPTH = full.
  assign occ   = tail - head;
  assign count = CNT_W'(occ);

  // Registered state plus flush/rst only; stall never feeds in_ready.
  assign in_ready = rst && !flush && (occ <= PTR_W'(DEPTH - FETCH_WIDTH));
  assign enq_fire = in_ready && (|in_valid);

`ifdef IBUF_BYPASS_EN
  localparam int BYP_W = (DECODE_WIDTH < FETCH_WIDTH) ? DECODE_WIDTH : FETCH_WIDTH;
  logic bypass;
  assign bypass  = (occ == '0) && !stall && in_ready;
  // Forwarded lanes are consumed by Decode this cycle and never written.
  assign fwd_num = !bypass ? '0 :
                   (int'(comp_num) > BYP_W) ? PTR_W'(BYP_W) : PTR_W'(comp_num);
`else
  assign fwd_num = '0;
`endif

  assign enq_wr  = enq_fire ? (PTR_W'(comp_num) - fwd_num) : '0;
  assign deq_num = (flush || stall) ? '0 :
                   (occ > PTR_W'(DECODE_WIDTH)) ? PTR_W'(DECODE_WIDTH) : occ;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head <= '0;
      tail <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
    end else begin
      head <= ibuf_ptr_t'(head + deq_num);
      tail <= ibuf_ptr_t'(tail + enq_wr);
    end
  end

  // Payload storage is not reset; only occupied slots are ever presented.
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      for (int j = 0; j < FETCH_WIDTH; j++) begin
        if ((PTR_W'(j) >= fwd_num) && (PTR_W'(j) < PTR_W'(comp_num))) begin
          mem[IDX_W'(tail.idx + IDX_W'(j) - IDX_W'(fwd_num))] <= comp_data[j*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  always_comb begin
    out_valid = '0;
    out_data  = '0;
    for (int j = 0; j < DECODE_WIDTH; j++) begin
      if (rst && !flush && (PTR_W'(j) < occ)) begin
        out_valid[j] = 1'b1;
        out_data[j*DATA_WIDTH +: DATA_WIDTH] = mem[IDX_W'(head.idx + IDX_W'(j))];
      end
    end
`ifdef IBUF_BYPASS_EN
    if (bypass) begin
      for (int j = 0; j < BYP_W; j++) begin
        if (PTR_W'(j) < fwd_num) begin
          out_valid[j] = 1'b1;
          out_data[j*DATA_WIDTH +: DATA_WIDTH] = comp_data[j*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
`endif
  end

endmodule

// File: tb/tb_inst_buffer.sv
// tb/tb_inst_buffer.sv - scoreboard bench for inst_buffer
module tb_inst_buffer;

  localparam int FW    = 4;
  localparam int DW    = 4;
  localparam int DEPTH = 16;
  localparam int DATAW = 96;

  logic              clk;
  logic              rst;
  logic              flush;
  logic [FW-1:0]     in_valid;
  logic [FW*DATAW-1:0] in_data;
  logic              in_ready;
  logic              stall;
  logic [DW-1:0]     out_valid;
  logic [DW*DATAW-1:0] out_data;
  logic [4:0]        count;

  int n_checks = 0;
  int n_errors = 0;

  // Payloads the DUT should currently hold, oldest first.
  logic [DATAW-1:0] exp_q[$];
  logic             byp_now = 1'b0;

  inst_buffer #(
    .FETCH_WIDTH  (FW),
    .DECODE_WIDTH (DW),
    .DEPTH        (DEPTH),
    .DATA_WIDTH   (DATAW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .stall     (stall),
    .out_valid (out_valid),
    .out_data  (out_data),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
    end
  endtask

  // Monitor: compares what the DUT presents against the scoreboard and
  // retires the presented entries on cycles that will dequeue.
  always @(negedge clk) begin
    int nv;
    int ec;
    int rdy;
    logic [DW-1:0] mask;
    ec   = byp_now ? 0 : exp_q.size();
    nv   = (!rst || flush) ? 0 : ((exp_q.size() > DW) ? DW : exp_q.size());
    mask = '0;
    for (int j = 0; j < nv; j++) mask[j] = 1'b1;
    rdy  = (rst && !flush && ec <= DEPTH - FW) ? 1 : 0;
    chk("count", int'(count), ec);
    chk("in_ready", int'(in_ready), rdy);
    chk("out_valid", int'(out_valid), int'(mask));
    for (int j = 0; j < nv; j++) begin
      n_checks++;
      if (out_data[j*DATAW +: DATAW] !== exp_q[j]) begin
        n_errors++;
        $display("FAIL out_data lane%0d: got %h expected %h at %0t",
                 j, out_data[j*DATAW +: DATAW], exp_q[j], $time);
      end
    end
    if (rst && !flush && !stall) begin
      for (int j = 0; j < nv; j++) void'(exp_q.pop_front());
    end
  end

  // Apply one cycle of stimulus (called just after a rising edge) and
  // update the scoreboard according to whether the group is accepted.
  task automatic step(input logic [FW-1:0] v, input logic s, input logic f);
    logic [DATAW-1:0] lanes[$];
    logic acc;
    lanes.delete();
    in_valid = v;
    stall    = s;
    flush    = f;
    for (int i = 0; i < FW; i++) begin
      in_data[i*DATAW +: DATAW] = {$urandom, $urandom, $urandom};
      if (v[i]) lanes.push_back(in_data[i*DATAW +: DATAW]);
    end
    acc = rst && !f && (exp_q.size() <= DEPTH - FW) && (v != '0);
`ifdef IBUF_BYPASS_EN
    if (acc && exp_q.size() == 0 && !s) begin
      byp_now = 1'b1;
      foreach (lanes[k]) exp_q.push_back(lanes[k]);
    end
`endif
    @(posedge clk);
    if (f) exp_q.delete();
    else if (acc && !byp_now) foreach (lanes[k]) exp_q.push_back(lanes[k]);
    byp_now = 1'b0;
    #1;
  endtask

  initial begin
    rst      = 1'b0;
    flush    = 1'b0;
    stall    = 1'b0;
    in_valid = '0;
    in_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;

    // Single full group, then lane compaction of a sparse mask.
    step(4'b1111, 0, 0);
    step(4'b0000, 0, 0);
    step(4'b0000, 0, 0);
    step(4'b1010, 0, 0);
    step(4'b0000, 0, 0);
    step(4'b0000, 0, 0);

    // Fill to full under stall; the fifth group must be dropped.
    repeat (5) step(4'b1111, 1, 0);
    repeat (5) step(4'b0000, 0, 0);

    // Hold 12 entries while enqueuing and dequeuing together; wraps pointers.
    repeat (3) step(4'b1111, 1, 0);
    repeat (7) step(4'b1111, 0, 0);
    repeat (4) step(4'b0000, 0, 0);

    // Flush at count 9 with a concurrent group, then accept right after.
    step(4'b1111, 1, 0);
    step(4'b1111, 1, 0);
    step(4'b0001, 1, 0);
    step(4'b1111, 0, 1);
    step(4'b1111, 0, 0);
    repeat (2) step(4'b0000, 0, 0);

    // Reset mid-traffic drops everything immediately.
    step(4'b1111, 1, 0);
    step(4'b0110, 1, 0);
    rst = 1'b0;
    exp_q.delete();
    #1;
    chk("out_valid_in_reset", int'(out_valid), 0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    step(4'b1111, 0, 0);
    repeat (2) step(4'b0000, 0, 0);

    // Randomised traffic.
    for (int c = 0; c < 400; c++) begin
      step(4'($urandom_range(0, 15)), ($urandom_range(0, 9) < 3),
           ($urandom_range(0, 39) == 0));
    end
    repeat (6) step(4'b0000, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
